// File: rtl/div_16bit_issue.sv
// rtl/div_16bit_issue.sv - operand-issue FIFO and result-capture stage for a 16-by-8 unsigned divider array
module div_16bit_issue #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [15:0]                in_a,
   input  logic [7:0]                 in_b,
   output logic [15:0]                div_a,
   output logic [7:0]                 div_b,
   input  logic [15:0]                div_q,
   input  logic [15:0]                div_r,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [15:0]                out_q,
   output logic [15:0]                out_r,
   output logic                       out_dbz,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [15:0]   r_mem_a [DEPTH];
   logic [7:0]    r_mem_b [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_out_valid;
   logic [15:0]   r_out_q;
   logic [15:0]   r_out_r;
   logic          r_out_dbz;

   logic          w_in_ready;
   logic          w_push;
   logic          w_not_empty;
   logic          w_out_free;
   logic          w_pop;
   logic [15:0]   w_head_a;
   logic [7:0]    w_head_b;

   // Handshake qualifiers; all derived from registered state so in_ready never depends on out_ready.
   assign w_in_ready  = (r_count < CW'(DEPTH));
   assign w_push      = in_valid && w_in_ready;
   assign w_not_empty = (r_count != '0);
   assign w_out_free  = !r_out_valid || out_ready;
   assign w_pop       = w_not_empty && w_out_free;

   // Head entry presented to the divider array; zeroed when the FIFO is empty.
   always_comb begin
      w_head_a = 16'h0;
      w_head_b = 8'h0;
      if (w_not_empty) begin
         w_head_a = r_mem_a[r_rd_ptr];
         w_head_b = r_mem_b[r_rd_ptr];
      end
   end

   // Operand storage; contents are unobservable while empty, so no reset is needed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wr_ptr] <= in_a;
         r_mem_b[r_wr_ptr] <= in_b;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Result register: capture divider output, or substitute saturated quotient on divide-by-zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_q     <= 16'h0;
         r_out_r     <= 16'h0;
         r_out_dbz   <= 1'b0;
      end else if (w_pop) begin
         r_out_valid <= 1'b1;
         if (w_head_b == 8'h0) begin
            r_out_q   <= 16'hFFFF;
            r_out_r   <= w_head_a;
            r_out_dbz <= 1'b1;
         end else begin
            r_out_q   <= div_q;
            r_out_r   <= div_r;
            r_out_dbz <= 1'b0;
         end
      end else if (w_out_free) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign div_a     = w_head_a;
   assign div_b     = w_head_b;
   assign out_valid = r_out_valid;
   assign out_q     = r_out_q;
   assign out_r     = r_out_r;
   assign out_dbz   = r_out_dbz;
   assign count     = r_count;

endmodule
